// File: rtl/step_pulse_sequencer.sv
// Step/direction pulse generator for a stepper driver: fixed-width step pulses at a clamped period,
// with direction setup delay and signed position tracking. First step rises one edge after the start decision.
module step_pulse_sequencer #(
  parameter int WIDTH      = 16,
  parameter int PULSE_W    = 50,
  parameter int DIR_SETUP  = 100,
  parameter int MIN_PERIOD = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    dir_in,
  input  logic [WIDTH-1:0]        period_in,
  input  logic                    period_valid,
  output logic                    drv_step,
  output logic                    drv_dir,
  output logic                    busy,
  output logic                    step_done,
  output logic signed [31:0]      position
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIR_WAIT   = 2'd1,
    PULSE_HIGH = 2'd2,
    PULSE_LOW  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MIN_P     = WIDTH'(MIN_PERIOD);
  localparam logic [15:0]      HIGH_LOAD = 16'(PULSE_W - 1);
  localparam logic [15:0]      DIR_LOAD  = 16'(DIR_SETUP - 1);
  localparam logic [15:0]      PW        = 16'(PULSE_W);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] period_reg;
  logic [WIDTH-1:0] p_eff;
  logic [15:0]      cnt;
  logic [15:0]      low_load;
  logic             run_ok;
  logic             dir_diff;
  logic             cnt_zero;
  logic             enter_high;
  logic             enter_low;
  logic             enter_dir;
  logic             enter_idle;

  assign run_ok   = enable && (period_reg != '0);
  assign dir_diff = (dir_in != drv_dir);
  assign cnt_zero = (cnt == 16'd0);
  // Counters run down to zero, so each phase loads its length minus one.
  assign low_load = 16'(p_eff) - PW - 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (run_ok) begin
          next_state = dir_diff ? DIR_WAIT : PULSE_HIGH;
        end
      end
      DIR_WAIT: begin
        if (cnt_zero) begin
          next_state = PULSE_HIGH;
        end
      end
      PULSE_HIGH: begin
        if (cnt_zero) begin
          next_state = PULSE_LOW;
        end
      end
      PULSE_LOW: begin
        if (cnt_zero) begin
          if (!run_ok) begin
            next_state = IDLE;
          end else if (dir_diff) begin
            next_state = DIR_WAIT;
          end else begin
            next_state = PULSE_HIGH;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    enter_high = (next_state == PULSE_HIGH) && (state != PULSE_HIGH);
    enter_low  = (next_state == PULSE_LOW)  && (state != PULSE_LOW);
    enter_dir  = (next_state == DIR_WAIT)   && (state != DIR_WAIT);
    enter_idle = (next_state == IDLE)       && (state != IDLE);
  end

  // Registered driver outputs and datapath; all updates keyed to state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_reg <= '0;
      p_eff      <= '0;
      cnt        <= 16'd0;
      drv_step   <= 1'b0;
      drv_dir    <= 1'b0;
      step_done  <= 1'b0;
      position   <= 32'sd0;
    end else begin
      step_done <= 1'b0;
      if (period_valid) begin
        period_reg <= period_in;
      end
      if (enter_high) begin
        drv_step  <= 1'b1;
        step_done <= 1'b1;
        p_eff     <= (period_reg < MIN_P) ? MIN_P : period_reg;
        cnt       <= HIGH_LOAD;
        position  <= drv_dir ? (position + 32'sd1) : (position - 32'sd1);
      end else if (enter_low) begin
        drv_step <= 1'b0;
        cnt      <= low_load;
      end else if (enter_dir) begin
        drv_dir <= dir_in;
        cnt     <= DIR_LOAD;
      end else if (enter_idle) begin
        cnt <= 16'd0;
      end else if (!cnt_zero) begin
        cnt <= cnt - 16'd1;
      end
    end
  end

endmodule

// File: doc/step_pulse_sequencer.md
STEP_PULSE_SEQUENCER -- requirements
Module: step_pulse_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: width of period_in and the period registers.
REQ-002 Parameter PULSE_W, default 50: drv_step high time, in clk cycles.
REQ-003 Parameter DIR_SETUP, default 100: clk cycles from a drv_dir change to the next drv_step rise.
REQ-004 Parameter MIN_PERIOD, default 200: minimum step period in clk cycles; must exceed PULSE_W.
REQ-005 clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 enable  input  1  motor run request, from the tracking FSM enable.
REQ-008 dir_in  input  1  requested direction; 1 = positive.
REQ-009 period_in  input  WIDTH  requested step period, in clk cycles.
REQ-010 period_valid  input  1  one-cycle strobe that loads period_in.
REQ-011 drv_step  output  1  registered step pulse to the driver.
REQ-012 drv_dir  output  1  registered direction to the driver.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 step_done  output  1  one-cycle strobe on the cycle drv_step rises.
REQ-015 position  output  32  signed step count; two's complement.

Function
REQ-016 period_reg SHALL load period_in on any clk edge with period_valid=1, in any state.
REQ-017 Each pulse SHALL latch P_eff = max(period_reg, MIN_PERIOD) on entry to PULSE_HIGH; changes to period_reg during a pulse SHALL NOT affect that pulse.
REQ-018 The FSM SHALL have four states: IDLE, DIR_WAIT, PULSE_HIGH, PULSE_LOW.
REQ-019 IDLE: drv_step=0 and busy=0.
REQ-020 IDLE SHALL stay in IDLE while enable=0 or period_reg=0.
REQ-021 IDLE with enable=1 and period_reg!=0: if dir_in!=drv_dir, go to DIR_WAIT; otherwise go to PULSE_HIGH.
REQ-022 Entry to DIR_WAIT: drv_dir<=dir_in in the same edge.
REQ-023 DIR_WAIT SHALL stay DIR_SETUP cycles, then go to PULSE_HIGH; dir_in changes during DIR_WAIT are ignored.
REQ-024 Entry to PULSE_HIGH, same edge:
- drv_step<=1 and step_done<=1 for exactly one cycle;
- position +1 if drv_dir=1, -1 if drv_dir=0.
REQ-025 PULSE_HIGH SHALL hold drv_step=1 for exactly PULSE_W cycles, then go to PULSE_LOW with drv_step<=0.
REQ-026 PULSE_LOW SHALL last P_eff-PULSE_W cycles, so successive drv_step rising edges are exactly P_eff cycles apart.
REQ-027 End of PULSE_LOW, in priority order:
- enable=0 or period_reg=0 -> IDLE;
- dir_in!=drv_dir -> DIR_WAIT;
- otherwise -> PULSE_HIGH.
REQ-028 enable falling mid-pulse SHALL NOT truncate PULSE_HIGH or PULSE_LOW; the block stops only at the end of PULSE_LOW.
REQ-029 drv_dir SHALL change only on entry to DIR_WAIT, never while drv_step=1 or during PULSE_LOW.
REQ-030 Latency: the drv_step rise SHALL occur one clk edge after the IDLE decision cycle; after a direction change it SHALL be DIR_SETUP+1 edges after it.
REQ-031 position SHALL wrap modulo 2^32 without saturation.
REQ-032 period_valid and an end-of-PULSE_LOW decision in the same cycle: the decision uses the old period_reg; the new value applies to the next latch.
REQ-033 The internal cycle counter SHALL be 16 bits wide.
REQ-034 The counter SHALL reload on every state entry.

Reset
REQ-035 rst=1 SHALL asynchronously force:
- state=IDLE;
- drv_step=0, drv_dir=0, step_done=0, busy=0;
- position=0, period_reg=0, counter=0.
REQ-036 rst asserted mid-pulse SHALL drop drv_step immediately; after release the FSM SHALL restart from IDLE with no partial pulse.

Verification
REQ-037 Load period 1000, enable=1, dir_in=0: drv_step rises every 1000 cycles, high 50; position -1 per pulse; drv_dir stays 0.
REQ-038 Load period 20 (below MIN_PERIOD): rising edges 200 cycles apart.
REQ-039 Load period 0 while running: the current pulse completes, then IDLE; busy=0 and no further steps.
REQ-040 Toggle dir_in to 1 mid-pulse at period 500:
- drv_dir changes only at the end of PULSE_LOW;
- next rise exactly 101 edges later;
- position then increments.
REQ-041 Drop enable 10 cycles into PULSE_HIGH: drv_step stays high 50 cycles, low phase completes, then IDLE; no further steps.
REQ-042 Assert rst 20 cycles into PULSE_HIGH:
- drv_step=0 immediately; position=0; period_reg=0;
- after release, no steps until period_valid reloads.
